jogador_automatico_genius: RTL
==============================

Name: jogador_automatico_genius

Overview:
- Automatic player for the memory game; drives the game's button inputs the way the game drives its LEDs.
- Watches the 7-bit LED output while the game presents a sequence and records each shown pattern into an internal buffer.
- Once presentation ends, replays the recorded patterns as timed press/release pulses on the game's button inputs.
- Used as a self-play bench driver and as an on-board demo mode, sitting between the game's LED outputs and its button inputs.

Parameters:
PROFUNDIDADE, 16, maximum number of patterns stored (>=2)
T_PRESS, 4, clock cycles each button pattern is held
T_GAP, 4, clock cycles of all-released between presses
T_ESPERA, 8, clock cycles between end of presentation and first press

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
habilita  input  1  enables the player; low aborts any activity
mostrando  input  1  high while the game is presenting the sequence
leds  input  7  LED pattern currently shown by the game
botoes  output  7  button pattern driven into the game (registered)
ocupado  output  1  high in any state other than OCIOSO
concluido  output  1  one-cycle pulse when the replay finishes
overflow  output  1  sticky; sequence exceeded PROFUNDIDADE
tamanho  output  $clog2(PROFUNDIDADE+1)  number of patterns captured
db_estado  output  3  current FSM state code

Behaviour:
- Reset (async, active-high):
  - state=OCIOSO; botoes=0; concluido=0; overflow=0; tamanho=0; pointers=0; previous-LED register=0.
  - Buffer contents need not be cleared.
- State codes: OCIOSO=0, CAPTURA=1, ESPERA=2, PRESSIONA=3, SOLTA=4, FIM=5.
- Priority each cycle: habilita=0 overrides all; then mostrando rising edge; then normal transitions.
- habilita=0 in any state: next state OCIOSO, botoes=0 next cycle. overflow and tamanho hold.
- OCIOSO:
  - botoes=0.
  - habilita=1 and mostrando=1 -> CAPTURA; tamanho cleared to 0; overflow cleared to 0.
- CAPTURA:
  - A capture event is a cycle where leds!=0 and leds differs from its value in the previous cycle (0->X, or X->Y with Y!=0).
  - On a capture event with tamanho<PROFUNDIDADE: store leds at mem[tamanho]; tamanho+1.
  - On a capture event with tamanho==PROFUNDIDADE: the pattern is dropped and overflow is set.
  - leds returning to 0 is not an event.
  - mostrando falling: -> ESPERA if tamanho>0, else -> OCIOSO.
  - A capture event in the same cycle mostrando falls is still stored.
- ESPERA:
  - botoes=0 for exactly T_ESPERA cycles.
  - Then -> PRESSIONA with read pointer=0.
- PRESSIONA:
  - botoes=mem[ptr] for exactly T_PRESS cycles.
  - Then -> SOLTA.
- SOLTA:
  - botoes=0 for exactly T_GAP cycles.
  - Then, if ptr==tamanho-1 -> FIM; else ptr+1 -> PRESSIONA.
- FIM:
  - concluido=1 for this single cycle; botoes=0.
  - Next -> OCIOSO.
- mostrando rising edge while in ESPERA, PRESSIONA or SOLTA (the game re-presents): -> CAPTURA next cycle.
  - botoes=0; tamanho cleared to 0; overflow cleared to 0.
- Patterns are stored and replayed verbatim; non-one-hot values are not filtered.
- botoes changes only on clock edges and is never X after reset.
- Timer counters are reloaded on every state entry.
- tamanho updates the cycle after its capture event.

Optional Feature:
- Macro JOGADOR_ERRO_EN.
- Defined:
  - Adds input injeta_erro (1 bit), sampled at entry to the last PRESSIONA of a replay.
  - If injeta_erro=1 at that point, that press drives mem[ptr] rotated left by one bit ({p[5:0],p[6]}) instead of mem[ptr].
  - Used to exercise the game's error path.
- Undefined: no injeta_erro port; replay is always verbatim.

Test Plan:
- Basic replay:
  - Stimulus: habilita=1, mostrando high, leds 0000001 -> 0 -> 0000100 -> 0, then mostrando low.
  - Required: after 8 cycles, botoes=0000001 for 4 cycles, 0 for 4 cycles, 0000100 for 4 cycles, 0 for 4 cycles; concluido pulses once; tamanho=2.
- Consecutive distinct patterns:
  - Stimulus: leds 0000010 -> 0001000 with no zero gap.
  - Required: both patterns captured; a constant 0000010 held for 10 cycles counts once.
- Overflow:
  - Stimulus: PROFUNDIDADE=16, present 17 distinct patterns.
  - Required: tamanho=16; overflow=1; the replay has exactly 16 presses and omits the 17th pattern.
- Abort:
  - Stimulus: drop habilita during the second PRESSIONA.
  - Required: the next cycle has botoes=0 and db_estado=0; no concluido pulse.
- Re-present:
  - Stimulus: mostrando rises during SOLTA.
  - Required: db_estado=1 the next cycle; tamanho=0; new capture proceeds normally.
- Async reset:
  - Stimulus: assert reset mid-PRESSIONA between clock edges.
  - Required: botoes=0 and db_estado=0 immediately; with JOGADOR_ERRO_EN and injeta_erro=1, the last press of 0000001 is driven as 0000010.

Source files
------------

// File: rtl/jogador_automatico_genius.sv
// Automatic player for the memory game.
// Records the LED patterns the game presents and then replays them as
// timed press/release pulses on the game's button inputs.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-high reset
//   habilita    enables the player; low sends it back to idle
//   mostrando   high while the game presents its sequence
//   leds        LED pattern shown by the game
//   injeta_erro (only with JOGADOR_ERRO_EN) corrupts the last replayed press
//   botoes      registered button pattern driven into the game
//   ocupado     high whenever the FSM is not idle
//   concluido   one-cycle pulse at the end of a replay
//   overflow    sticky; the presented sequence exceeded PROFUNDIDADE
//   tamanho     number of patterns captured
//   db_estado   current FSM state code
//
// Optional feature macro: JOGADOR_ERRO_EN (adds injeta_erro).
module jogador_automatico_genius #(
    parameter int unsigned PROFUNDIDADE = 16,
    parameter int unsigned T_PRESS      = 4,
    parameter int unsigned T_GAP        = 4,
    parameter int unsigned T_ESPERA     = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                habilita,
    input  logic                                mostrando,
    input  logic [6:0]                          leds,
`ifdef JOGADOR_ERRO_EN
    input  logic                                injeta_erro,
`endif
    output logic [6:0]                          botoes,
    output logic                                ocupado,
    output logic                                concluido,
    output logic                                overflow,
    output logic [$clog2(PROFUNDIDADE+1)-1:0]   tamanho,
    output logic [2:0]                          db_estado
);

    localparam int unsigned W_TAM   = $clog2(PROFUNDIDADE + 1);
    localparam int unsigned W_PTR   = $clog2(PROFUNDIDADE);
    localparam int unsigned T_MAX1  = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
    localparam int unsigned T_MAX   = (T_MAX1 > T_ESPERA) ? T_MAX1 : T_ESPERA;
    localparam int unsigned W_TEMPO = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CAPTURA   = 3'd1,
        ESPERA    = 3'd2,
        PRESSIONA = 3'd3,
        SOLTA     = 3'd4,
        FIM       = 3'd5
    } estado_t;

    estado_t              estado;
    logic [W_PTR-1:0]     ptr;
    logic [W_TEMPO-1:0]   tempo;
    logic [6:0]           leds_ant;
    logic                 mostrando_ant;
    logic [6:0]           mem [PROFUNDIDADE];

    logic                 evento;
    logic                 subida;
    logic                 cheio;
    logic                 ultimo;
    logic                 erro_espera;
    logic                 erro_solta;
    logic [6:0]           padrao_primeiro;
    logic [6:0]           padrao_proximo;

    // A new non-zero pattern that differs from last cycle is a capture event
    assign evento  = (leds != 7'd0) && (leds != leds_ant);
    assign subida  = mostrando && !mostrando_ant;
    assign cheio   = (tamanho == W_TAM'(PROFUNDIDADE));
    assign ultimo  = ((W_TAM'(ptr) + W_TAM'(1)) == tamanho);

    assign ocupado   = (estado != OCIOSO);
    assign db_estado = estado;

    // Error injection applies only to the final press of a replay
`ifdef JOGADOR_ERRO_EN
    assign erro_espera = injeta_erro && (tamanho == W_TAM'(1));
    assign erro_solta  = injeta_erro && ((W_TAM'(ptr) + W_TAM'(2)) == tamanho);
`else
    assign erro_espera = 1'b0;
    assign erro_solta  = 1'b0;
`endif

    // Pattern to load into botoes on PRESSIONA entry (rotated left when corrupted)
    always_comb begin
        padrao_primeiro = mem[0];
        padrao_proximo  = mem[ptr + W_PTR'(1)];
        if (erro_espera) begin
            padrao_primeiro = {mem[0][5:0], mem[0][6]};
        end
        if (erro_solta) begin
            padrao_proximo = {mem[ptr + W_PTR'(1)][5:0], mem[ptr + W_PTR'(1)][6]};
        end
    end

    // Pattern buffer; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (habilita && (estado == CAPTURA) && evento && !cheio) begin
            mem[W_PTR'(tamanho)] <= leds;
        end
    end

    // Main FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            botoes        <= 7'd0;
            concluido     <= 1'b0;
            overflow      <= 1'b0;
            tamanho       <= '0;
            ptr           <= '0;
            tempo         <= '0;
            leds_ant      <= 7'd0;
            mostrando_ant <= 1'b0;
        end else begin
            leds_ant      <= leds;
            mostrando_ant <= mostrando;
            concluido     <= 1'b0;

            if (!habilita) begin
                estado <= OCIOSO;
                botoes <= 7'd0;
            end else if (subida && ((estado == ESPERA) || (estado == PRESSIONA) ||
                                    (estado == SOLTA))) begin
                // Game re-presents: discard the old sequence and capture again
                estado   <= CAPTURA;
                botoes   <= 7'd0;
                tamanho  <= '0;
                overflow <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        botoes <= 7'd0;
                        if (mostrando) begin
                            estado   <= CAPTURA;
                            tamanho  <= '0;
                            overflow <= 1'b0;
                        end
                    end

                    CAPTURA: begin
                        botoes <= 7'd0;
                        if (evento) begin
                            if (!cheio) begin
                                tamanho <= tamanho + W_TAM'(1);
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        // An event in the falling cycle still counts as captured
                        if (!mostrando) begin
                            if ((tamanho != '0) || evento) begin
                                estado <= ESPERA;
                                tempo  <= W_TEMPO'(T_ESPERA - 1);
                            end else begin
                                estado <= OCIOSO;
                            end
                        end
                    end

                    ESPERA: begin
                        botoes <= 7'd0;
                        if (tempo == '0) begin
                            estado <= PRESSIONA;
                            ptr    <= '0;
                            tempo  <= W_TEMPO'(T_PRESS - 1);
                            botoes <= padrao_primeiro;
                        end else begin
                            tempo <= tempo - W_TEMPO'(1);
                        end
                    end

                    PRESSIONA: begin
                        if (tempo == '0) begin
                            estado <= SOLTA;
                            tempo  <= W_TEMPO'(T_GAP - 1);
                            botoes <= 7'd0;
                        end else begin
                            tempo <= tempo - W_TEMPO'(1);
                        end
                    end

                    SOLTA: begin
                        botoes <= 7'd0;
                        if (tempo == '0) begin
                            if (ultimo) begin
                                estado    <= FIM;
                                concluido <= 1'b1;
                            end else begin
                                estado <= PRESSIONA;
                                ptr    <= ptr + W_PTR'(1);
                                tempo  <= W_TEMPO'(T_PRESS - 1);
                                botoes <= padrao_proximo;
                            end
                        end else begin
                            tempo <= tempo - W_TEMPO'(1);
                        end
                    end

                    FIM: begin
                        botoes <= 7'd0;
                        estado <= OCIOSO;
                    end

                    default: begin
                        botoes <= 7'd0;
                        estado <= OCIOSO;
                    end
                endcase
            end
        end
    end

endmodule
